// File: rtl/risc_core_pkg.sv
// risc_core_pkg: shared opcodes, FSM state encoding and instruction field positions for risc_core_mc.
// Contents: OP_* opcode constants, state_t FSM encoding, field bit positions, reg_live() index qualifier.
package risc_core_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam int OP_HI    = 15;
    localparam int OP_LO    = 13;
    localparam int RA_HI    = 12;
    localparam int RA_LO    = 10;
    localparam int RB_HI    = 9;
    localparam int RB_LO    = 7;
    localparam int RC_HI    = 2;
    localparam int RC_LO    = 0;
    localparam int IMM_HI   = 6;
    localparam int IMM10_HI = 9;

    // A register index is live only if it is not r0 and lies below the implemented count.
    function automatic logic reg_live(input logic [2:0] idx, input int nregs);
        return idx != 3'd0 && int'(idx) < nregs;
    endfunction

endpackage

// File: rtl/risc_regfile.sv
// risc_regfile: 2-read/1-write register file; r0 and unimplemented indices read 0 and ignore writes.
// Ports:
//   clk             clock
//   we/waddr/wdata  write port, takes effect at the clock edge
//   raddr1/rdata1   combinational read port 1
//   raddr2/rdata2   combinational read port 2
module risc_regfile
    import risc_core_pkg::*;
#(
    parameter int XLEN  = 16,
    parameter int NREGS = 8
) (
    input  logic            clk,
    input  logic            we,
    input  logic [2:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      raddr1,
    input  logic [2:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [8];

    always_ff @(posedge clk)
        if (we && reg_live(waddr, NREGS))
            regs[waddr] <= wdata;

    assign rdata1 = reg_live(raddr1, NREGS) ? regs[raddr1] : '0;
    assign rdata2 = reg_live(raddr2, NREGS) ? regs[raddr2] : '0;

endmodule

// File: rtl/risc_core_mc.sv
// risc_core_mc: multi-cycle 8-opcode core with req/ack instruction and data memory ports.
// Optional macro RISC_CORE_HALT_EN: JALR with nonzero ir[6:0] stops the core until reset.
// Ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   imem_req, imem_addr                  fetch request, fetch address (= pc)
//   imem_rdata, imem_ack                 instruction word, fetch complete
//   dmem_req, dmem_we, dmem_addr, dmem_wdata  data request, 1=store, address, store data
//   dmem_rdata, dmem_ack                 load data, transfer complete
//   retire                               one-cycle pulse per completed instruction
//   halted                               core stopped by HALT (tied 0 without the macro)
module risc_core_mc
    import risc_core_pkg::*;
#(
    parameter int              XLEN     = 16,
    parameter int              PC_W     = 16,
    parameter int              NREGS    = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_ack,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ack,
    output logic            retire,
    output logic            halted
);

    state_t          state;
    logic [15:0]     ir;
    logic [PC_W-1:0] pc, pc_inc, pc_next;
    logic [2:0]      op, ra, rb, rc, rsel;
    logic [XLEN-1:0] q1, q2, simm, alu, wdata;
    logic            mem_op, is_halt, wen;

    assign op     = ir[OP_HI:OP_LO];
    assign ra     = ir[RA_HI:RA_LO];
    assign rb     = ir[RB_HI:RB_LO];
    assign rc     = ir[RC_HI:RC_LO];
    // Port 2 reads rC for the two register-register ALU ops, rA otherwise (BEQ compare, store data).
    assign rsel   = (op == OP_ADD || op == OP_NAND) ? rc : ra;
    assign simm   = XLEN'($signed(ir[IMM_HI:0]));
    assign mem_op = op == OP_SW || op == OP_LW;
    assign pc_inc = pc + PC_W'(1);
    assign imem_addr = pc;

`ifdef RISC_CORE_HALT_EN
    assign is_halt = op == OP_JALR && ir[IMM_HI:0] != '0;
`else
    assign is_halt = 1'b0;
`endif

    always_comb begin
        alu = op == OP_ADD  ? q1 + q2 :
              op == OP_ADDI ? q1 + simm :
              op == OP_NAND ? ~(q1 & q2) :
              op == OP_LUI  ? XLEN'({ir[IMM10_HI:0], 6'b0}) :
                              XLEN'(pc_inc);
        pc_next = op == OP_JALR ? PC_W'(q1) :
                  (op == OP_BEQ && q1 == q2) ? pc_inc + PC_W'($signed(ir[IMM_HI:0])) :
                  pc_inc;
    end

    // Write enable is qualified by rst_n so an ack landing during reset cannot commit a load.
    assign wen   = rst_n && ((state == S_EXEC && !mem_op && op != OP_BEQ && !is_halt) ||
                             (state == S_MEM && dmem_req && dmem_ack && !dmem_we));
    assign wdata = state == S_MEM ? dmem_rdata : alu;

    risc_regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk    (clk),
        .we     (wen),
        .waddr  (ra),
        .wdata  (wdata),
        .raddr1 (rb),
        .raddr2 (rsel),
        .rdata1 (q1),
        .rdata2 (q2)
    );

    // imem_req is registered, so the first FETCH cycle after reset carries no request;
    // any ack seen then is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            retire     <= 1'b0;
        end else begin
            retire <= 1'b0;
            case (state)
                S_FETCH:
                    if (imem_req && imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_EXEC;
                    end else
                        imem_req <= 1'b1;
                S_EXEC:
                    if (mem_op) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= op == OP_SW;
                        dmem_addr  <= q1 + simm;
                        dmem_wdata <= q2;
                        state      <= S_MEM;
                    end else if (is_halt) begin
                        retire <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        pc       <= pc_next;
                        retire   <= 1'b1;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                S_MEM:
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        pc       <= pc_inc;
                        retire   <= 1'b1;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                default: ;
            endcase
        end
    end

`ifdef RISC_CORE_HALT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            halted <= 1'b0;
        else if (state == S_EXEC && is_halt)
            halted <= 1'b1;
    end
`else
    assign halted = 1'b0;
`endif

endmodule
